ads1284_sample_reader: RTL

//  Downstream consumer of the data-ready pulse (datardy_fall) produced in the ADC control path.
//  On each pulse, runs one SPI read frame to the ADS1284 and shifts in a SAMPLE_W-bit conversion word.

---
 rtl/ads1284_pkg.sv | 17 +
 rtl/sync_fifo_fwft.sv | 50 +++++
 rtl/ads1284_sample_reader.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ads1284_pkg.sv
// rtl/ads1284_pkg.sv - shared state, error-bit and width definitions for the ADS1284 sample reader
package ads1284_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    PUSH
  } reader_state_t;

  localparam int ERR_OVF          = 0;
  localparam int ERR_MISS         = 1;
  localparam int DEFAULT_SAMPLE_W = 32;
  localparam int TS_W             = 32;

endpackage

// File: rtl/sync_fifo_fwft.sv
// rtl/sync_fifo_fwft.sv - first-word-fall-through FIFO, head word visible while valid
module sync_fifo_fwft #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     valid,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_cnt;
  logic [AW:0]      rd_cnt;
  logic             do_rd;
  logic             do_wr;

  // Counters carry one extra wrap bit so full and empty stay distinguishable.
  assign level   = wr_cnt - rd_cnt;
  assign valid   = (level != '0);
  assign full    = (level == FULL_LVL);
  assign do_rd   = rd_en & valid;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_cnt[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_cnt[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (do_wr) wr_cnt <= wr_cnt + 1'b1;
      if (do_rd) rd_cnt <= rd_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ads1284_sample_reader.sv
// rtl/ads1284_sample_reader.sv - per-drdy SPI read of one ADS1284 word into a FWFT sample FIFO
// Optional ADS_READER_TIMESTAMP_EN stores a free-running cycle stamp with each word (port sample_ts).
module ads1284_sample_reader
  import ads1284_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int CS_SETUP   = 2,
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          drdy_fall,
  output logic                          adc_cs_n,
  output logic                          adc_sclk,
  input  logic                          adc_dout,
  output logic [SAMPLE_W-1:0]           sample_data,
`ifdef ADS_READER_TIMESTAMP_EN
  output logic [TS_W-1:0]               sample_ts,
`endif
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [1:0]                    err_sticky,
  input  logic                          err_clr,
  output logic                          busy
);

  localparam int DIV_W   = $clog2(2*CLK_DIV);
  localparam int SETUP_W = $clog2(CS_SETUP+1);
  localparam int BIT_W   = $clog2(SAMPLE_W);
  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(2*CLK_DIV-1);
  localparam logic [DIV_W-1:0]   HIGH_LAST  = DIV_W'(CLK_DIV-1);
  localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(CS_SETUP-1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(SAMPLE_W-1);
`ifdef ADS_READER_TIMESTAMP_EN
  localparam int FIFO_W = SAMPLE_W + TS_W;
`else
  localparam int FIFO_W = SAMPLE_W;
`endif

  reader_state_t         state;
  logic [SETUP_W-1:0]    setup_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [SAMPLE_W-1:0]   shreg;
  logic                  push;
  logic                  fifo_full;
  logic                  ovf_set;
  logic                  miss_set;
  logic                  accept;
  logic [FIFO_W-1:0]     fifo_wr_data;
  logic [FIFO_W-1:0]     fifo_rd_data;

  assign accept   = (state == IDLE) & drdy_fall & enable;
  assign push     = (state == PUSH);
  assign ovf_set  = push & fifo_full & ~sample_ready;
  assign miss_set = drdy_fall & enable & busy;

  // Outputs are registered, so cs_n rises one cycle after HOLD is entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      adc_cs_n  <= 1'b1;
      adc_sclk  <= 1'b0;
      busy      <= 1'b0;
      setup_cnt <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state     <= SETUP;
            adc_cs_n  <= 1'b0;
            busy      <= 1'b1;
            setup_cnt <= '0;
          end
        end
        SETUP: begin
          if (setup_cnt == SETUP_LAST) begin
            state    <= SHIFT;
            adc_sclk <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= BIT_LAST;
            shreg    <= {shreg[SAMPLE_W-2:0], adc_dout};
          end else begin
            setup_cnt <= setup_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            if (bit_cnt == '0) begin
              state <= HOLD;
            end else begin
              bit_cnt  <= bit_cnt - 1'b1;
              div_cnt  <= '0;
              adc_sclk <= 1'b1;
              shreg    <= {shreg[SAMPLE_W-2:0], adc_dout};
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == HIGH_LAST) adc_sclk <= 1'b0;
          end
        end
        HOLD: begin
          adc_cs_n <= 1'b1;
          state    <= PUSH;
        end
        PUSH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A new error in the same cycle as err_clr keeps the bit set.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky <= '0;
    end else begin
      err_sticky[ERR_OVF]  <= ovf_set  | (err_sticky[ERR_OVF]  & ~err_clr);
      err_sticky[ERR_MISS] <= miss_set | (err_sticky[ERR_MISS] & ~err_clr);
    end
  end

`ifdef ADS_READER_TIMESTAMP_EN
  logic [TS_W-1:0] ts_cnt;
  logic [TS_W-1:0] ts_lat;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_cnt <= '0;
      ts_lat <= '0;
    end else begin
      ts_cnt <= ts_cnt + 1'b1;
      if (accept) ts_lat <= ts_cnt;
    end
  end

  assign fifo_wr_data = {ts_lat, shreg};
  assign sample_ts    = fifo_rd_data[FIFO_W-1:SAMPLE_W];
`else
  assign fifo_wr_data = shreg;
`endif
  assign sample_data  = fifo_rd_data[SAMPLE_W-1:0];

  sync_fifo_fwft #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (fifo_wr_data),
    .rd_en   (sample_ready),
    .rd_data (fifo_rd_data),
    .valid   (sample_valid),
    .full    (fifo_full),
    .level   (fifo_level)
  );

endmodule
